// File: rtl/rv32i_types.sv
// Shared types and constants for the instruction fetch path.
package rv32i_types;

    // Fetch FSM: IDLE = buffer full, REQ = fetching at pc, KILL = waiting out a stale read.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Canonical RV32I NOP (addi x0, x0, 0), presented whenever the head is empty.
    localparam logic [31:0] NOP = 32'h00000013;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO between the fetch FSM and decode.
module fetch_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_inst,
    input  logic        pop,
    input  logic        flush,
    output logic [1:0]  count,
    output logic        head_valid,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst
);

    localparam logic [1:0] CAPACITY = 2'(DEPTH);

    fetch_entry_t mem [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         full;
    logic         push_ok;
    logic         pop_ok;

    assign full       = (count_reg == CAPACITY);
    assign head_valid = (count_reg != 2'd0);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && head_valid;
    assign count      = count_reg;
    assign head_pc    = mem[rd_ptr_reg].pc;
    assign head_inst  = mem[rd_ptr_reg].inst;

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_reg] <= '{pc: push_pc, inst: push_inst};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: keeps a 2-deep buffer filled from instruction memory,
// handles decode stalls and branch redirects (including reads already in flight).
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000060,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        i_read,
    output logic [31:0] i_address,
    input  logic        i_resp,
    input  logic [31:0] i_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  kill_addr_reg, kill_addr_next;

    logic [1:0]   count;
    logic [1:0]   count_after;
    logic         head_valid;
    logic [31:0]  head_pc;
    logic [31:0]  head_inst;
    logic         push;
    logic         pop;

    // Redirect wins over both push and pop.
    assign pop         = head_valid && !stall;
    assign push        = (state_reg == REQ) && i_resp && !redirect;
    assign count_after = count + {1'b0, push} - {1'b0, pop};

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (pc_reg),
        .push_inst  (i_rdata),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_inst  (head_inst)
    );

    // Next-state, next-pc and stale-address selection.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        kill_addr_next = kill_addr_reg;
        if (redirect) begin
            pc_next = align_word(redirect_pc);
            unique case (state_reg)
                IDLE: state_next = REQ;
                REQ: begin
                    if (!i_resp) begin
                        // Read still outstanding: keep presenting it until memory answers.
                        state_next     = KILL;
                        kill_addr_next = pc_reg;
                    end
                end
                // The stale read may complete in this same cycle; only then leave KILL.
                KILL: if (i_resp) state_next = REQ;
                default: state_next = REQ;
            endcase
        end else begin
            unique case (state_reg)
                IDLE: if (pop) state_next = REQ;
                REQ: begin
                    if (i_resp) begin
                        pc_next    = pc_reg + 32'd4;
                        state_next = (count_after == 2'd2) ? IDLE : REQ;
                    end
                end
                KILL: if (i_resp) state_next = REQ;
                default: state_next = REQ;
            endcase
        end
    end

    // FSM and address registers; reset leaves a fetch of RESET_PC pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= REQ;
            pc_reg        <= align_word(RESET_PC);
            kill_addr_reg <= align_word(RESET_PC);
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            kill_addr_reg <= kill_addr_next;
        end
    end

    // The read request is masked directly by reset so it drops immediately.
    assign i_read      = rst && (state_reg != IDLE);
    assign i_address   = (state_reg == KILL) ? kill_addr_reg : pc_reg;
    assign inst_valid  = head_valid;
    assign instruction = head_valid ? head_inst : NOP;
    assign pc_out      = head_valid ? head_pc : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table vectors, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP_W = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        i_read;
    logic [31:0] i_address;
    logic        i_resp;
    logic [31:0] i_rdata;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h00000060),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_resp      (i_resp),
        .i_rdata     (i_rdata),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .pc_out      (pc_out)
    );

    typedef struct {
        logic        stall;
        logic        resp;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs [9];

    // Reference model: buffer as queues, fetch whenever there is room or a stale read is pending.
    logic [31:0] q_pc   [$];
    logic [31:0] q_inst [$];
    logic [31:0] m_pc;
    logic [31:0] m_kaddr;
    bit          m_kill;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_read, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
        chk({tag, ".i_read"},      32'(i_read),     32'(e_read));
        chk({tag, ".i_address"},   i_address,       e_addr);
        chk({tag, ".inst_valid"},  32'(inst_valid), 32'(e_valid));
        chk({tag, ".pc_out"},      pc_out,          e_pc);
        chk({tag, ".instruction"}, instruction,     e_inst);
    endtask

    // Drive one cycle of inputs (called at the falling edge) and return at the next falling edge.
    task automatic step(input logic s, input logic r, input logic [31:0] d,
                        input logic rd, input logic [31:0] rp);
        stall       = s;
        i_resp      = r;
        i_rdata     = d;
        redirect    = rd;
        redirect_pc = rp;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        stall = 1'b0; i_resp = 1'b0; i_rdata = '0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        chk_out({tag, ".in_reset"}, 1'b0, 32'h60, 1'b0, 32'h0, NOP_W);
        rst = 1'b1;
        #1;
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_inst.delete();
        m_pc    = 32'h60;
        m_kaddr = 32'h60;
        m_kill  = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] d,
                              input logic rd, input logic [31:0] rp);
        bit fetching;
        bit do_pop;
        fetching = m_kill || (q_pc.size() < 2);
        do_pop   = (q_pc.size() > 0) && !s;
        if (rd) begin
            if (m_kill) begin
                if (r) m_kill = 1'b0;
            end else if (fetching && !r) begin
                m_kill  = 1'b1;
                m_kaddr = m_pc;
            end
            q_pc.delete();
            q_inst.delete();
            m_pc = rp & 32'hFFFF_FFFC;
        end else begin
            if (do_pop) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (m_kill) begin
                if (r) m_kill = 1'b0;
            end else if (fetching && r) begin
                q_pc.push_back(m_pc);
                q_inst.push_back(d);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        // Stream after reset with a 5-cycle stall: addresses 60, 64, 68; buffer caps at 2.
        vecs[0] = '{1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 32'h0,  NOP_W};
        vecs[1] = '{1'b1, 1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b1, 32'h64, 1'b1, 32'h60, 32'h1111_1111};
        vecs[2] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h68, 1'b1, 32'h60, 32'h1111_1111};
        vecs[3] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h68, 1'b1, 32'h60, 32'h1111_1111};
        vecs[4] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h68, 1'b1, 32'h60, 32'h1111_1111};
        vecs[5] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h68, 1'b1, 32'h60, 32'h1111_1111};
        vecs[6] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h68, 1'b1, 32'h60, 32'h1111_1111};
        vecs[7] = '{1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b1, 32'h68, 1'b1, 32'h64, 32'h2222_2222};
        vecs[8] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 32'h6C, 1'b1, 32'h68, 32'h3333_3333};

        @(negedge clk);
        do_reset("tbl");
        for (int i = 0; i < 9; i++) begin
            chk_out($sformatf("vec%0d", i), vecs[i].e_read, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst);
            step(vecs[i].stall, vecs[i].resp, vecs[i].rdata, vecs[i].redir, vecs[i].rpc);
        end

        // Redirect while the read of 0x64 is still waiting: address held, data dropped.
        do_reset("s37");
        chk_out("s37.c0", 1'b1, 32'h60, 1'b0, 32'h0, NOP_W);
        step(1'b0, 1'b1, 32'hAAAA_0060, 1'b0, 32'h0);
        chk_out("s37.c1", 1'b1, 32'h64, 1'b1, 32'h60, 32'hAAAA_0060);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
        chk_out("s37.kill1", 1'b1, 32'h64, 1'b0, 32'h0, NOP_W);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_out("s37.kill2", 1'b1, 32'h64, 1'b0, 32'h0, NOP_W);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        chk_out("s37.refetch", 1'b1, 32'h200, 1'b0, 32'h0, NOP_W);
        step(1'b0, 1'b1, 32'hC000_0200, 1'b0, 32'h0);
        chk_out("s37.first", 1'b1, 32'h204, 1'b1, 32'h200, 32'hC000_0200);

        // Redirect to an unaligned target in the same cycle as a response.
        step(1'b0, 1'b1, 32'hBAD0_0204, 1'b1, 32'h303);
        chk_out("s38.redir", 1'b1, 32'h300, 1'b0, 32'h0, NOP_W);
        step(1'b0, 1'b1, 32'hE000_0300, 1'b0, 32'h0);
        chk_out("s38.first", 1'b1, 32'h304, 1'b1, 32'h300, 32'hE000_0300);

        // Simultaneous push and pop for 4 cycles keeps order, then fill up and drain one.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 32'hF000_0000 + 32'(k), 1'b0, 32'h0);
            chk_out($sformatf("s39.pp%0d", k), 1'b1, 32'h308 + 32'(4 * k), 1'b1,
                    32'h304 + 32'(4 * k), 32'hF000_0000 + 32'(k));
        end
        step(1'b1, 1'b1, 32'h6666_0314, 1'b0, 32'h0);
        chk_out("s39.full", 1'b0, 32'h318, 1'b1, 32'h310, 32'hF000_0003);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_out("s39.hold", 1'b0, 32'h318, 1'b1, 32'h310, 32'hF000_0003);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_out("s39.drain", 1'b1, 32'h318, 1'b1, 32'h314, 32'h6666_0314);

        // Asynchronous reset while a stale read is pending.
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h400);
        chk_out("s40.kill", 1'b1, 32'h318, 1'b0, 32'h0, NOP_W);
        #2 rst = 1'b0;
        #1 chk_out("s40.async", 1'b0, 32'h60, 1'b0, 32'h0, NOP_W);
        @(negedge clk);
        stall = 1'b0; i_resp = 1'b0; redirect = 1'b0;
        rst = 1'b1;
        #1 chk_out("s40.release", 1'b1, 32'h60, 1'b0, 32'h0, NOP_W);
        step(1'b0, 1'b1, 32'h4444_0060, 1'b0, 32'h0);
        chk_out("s40.first", 1'b1, 32'h64, 1'b1, 32'h60, 32'h4444_0060);

        // Address wrap at the top of memory.
        step(1'b0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFF);
        chk_out("wrap.redir", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP_W);
        step(1'b0, 1'b1, 32'h7777_FFFC, 1'b0, 32'h0);
        chk_out("wrap.next", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h7777_FFFC);

        // Randomized traffic against the reference model.
        do_reset("rnd");
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        s, r, rd, m_read;
            logic [31:0] d, rp;
            m_read = m_kill || (q_pc.size() < 2);
            chk_out($sformatf("rnd%0d", c), m_read, m_kill ? m_kaddr : m_pc,
                    q_pc.size() > 0, (q_pc.size() > 0) ? q_pc[0] : 32'h0,
                    (q_inst.size() > 0) ? q_inst[0] : NOP_W);
            s  = ($urandom_range(3) == 0);
            r  = m_read && ($urandom_range(2) != 0);
            d  = $urandom;
            rd = ($urandom_range(15) == 0);
            case ($urandom_range(2))
                0:       rp = $urandom;
                1:       rp = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                default: rp = 32'h100 + 32'($urandom_range(63));
            endcase
            model_step(s, r, d, rd, rp);
            step(s, r, d, rd, rp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000060, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 stall  input  1  downstream decode stall; head entry is not consumed while 1.
REQ-006 redirect  input  1  branch/jump taken; flush buffer and refetch from redirect_pc.
REQ-007 redirect_pc  input  32  new fetch address.
REQ-008 i_read  output  1  instruction memory read request.
REQ-009 i_address  output  32  instruction memory address, word-aligned.
REQ-010 i_resp  input  1  memory response; i_rdata valid this cycle.
REQ-011 i_rdata  input  32  returned instruction word.
REQ-012 inst_valid  output  1  buffer head holds a valid instruction.
REQ-013 instruction  output  32  head instruction; NOP 32'h00000013 when inst_valid=0.
REQ-014 pc_out  output  32  address of head instruction; 0 when inst_valid=0.

Function
REQ-015 States SHALL be IDLE (buffer full, no request), REQ (i_read=1, address=pc), KILL (i_read=1 on stale address, response discarded).
REQ-016 In REQ, i_read and i_address SHALL remain stable until i_resp=1.
REQ-017 REQ with i_resp=1 and no redirect SHALL push {pc, i_rdata} and advance pc by 4.
REQ-018 After a push, the next state SHALL be IDLE if the resulting count equals 2, else REQ.
REQ-019 A pop SHALL occur when inst_valid=1 and stall=0; the head is removed at the clock edge.
REQ-020 IDLE SHALL go to REQ in the cycle after a pop leaves count below 2.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-022 A push into a full buffer SHALL never occur; a full buffer suppresses i_read.
REQ-023 Redirect SHALL take priority over push and pop: buffer empties, pc=redirect_pc with bits [1:0] forced to 0.
REQ-024 Redirect in REQ with i_resp=0 SHALL enter KILL, holding the old address until i_resp, then discard the data and enter REQ.
REQ-025 Redirect in the same cycle as i_resp SHALL discard that data and enter REQ at the new pc next cycle.
REQ-026 Redirect in IDLE or KILL SHALL enter REQ or stay in KILL respectively; a later redirect in KILL only updates pc.
REQ-027 inst_valid SHALL be 0 in the cycle after any redirect.
REQ-028 Fetch-to-output latency SHALL be one cycle: data accepted on i_resp appears at head on the next cycle when the buffer was empty.
REQ-029 pc arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.

Reset
REQ-030 While rst=0: pc=RESET_PC, state=REQ pending, buffer empty, i_read=0, inst_valid=0, instruction=NOP, pc_out=0.
REQ-031 The first cycle after rst deasserts SHALL assert i_read with i_address=RESET_PC.
REQ-032 A reset during an outstanding request SHALL abandon it; the memory side tolerates the dropped read.

Structure
REQ-033 The fetch_state_t enum (IDLE, REQ, KILL) and NOP constant SHALL be defined in rv32i_types.
REQ-034 The buffer SHALL be a sub-module fetch_buffer (2-entry FIFO: push, pop, flush, count, head outputs).

Verification
REQ-035 Reset release, i_resp after 1 cycle each, stall=0 -> i_address sequence 0x60, 0x64, 0x68, and inst_valid rises on the cycle after the first resp with pc_out=0x60.
REQ-036 stall=1 held for 5 cycles -> exactly 2 entries buffered, i_read=0, head stays pc_out=0x60; stall=0 -> i_read reasserts the next cycle at 0x68.
REQ-037 Redirect to 0x200 while a read to 0x64 waits 3 cycles -> i_address stays 0x64 until resp, data dropped, then i_address=0x200 and the first valid pc_out=0x200.
REQ-038 Redirect to 0x303 coincident with i_resp -> response discarded, next i_address=0x300, inst_valid=0 that cycle.
REQ-039 Full buffer with simultaneous pop and push across 4 cycles -> order preserved and count never exceeds 2.
REQ-040 rst asserted mid-KILL -> outputs reach their reset values immediately (asynchronous), and after release the first i_address=0x60.
